// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module   : inst_fetch_queue
// Brief    : Dual-issue in-order instruction buffer between I-cache return and
//            decode. Optional high-water-mark output under `IFQ_HWM_EN`.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int DEPTH   = 8,
  parameter int CAUSE_W = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [31:0]            in_pc0,
  input  logic [31:0]            in_pc1,
  input  logic [31:0]            in_inst0,
  input  logic [31:0]            in_inst1,
  input  logic                   in_excp0,
  input  logic                   in_excp1,
  input  logic [CAUSE_W-1:0]     in_cause0,
  input  logic [CAUSE_W-1:0]     in_cause1,
  output logic                   fq_full_stall,
  output logic [1:0]             out_valid,
  output logic [31:0]            out_pc0,
  output logic [31:0]            out_pc1,
  output logic [31:0]            out_inst0,
  output logic [31:0]            out_inst1,
  output logic                   out_excp0,
  output logic                   out_excp1,
  output logic [CAUSE_W-1:0]     out_cause0,
  output logic [CAUSE_W-1:0]     out_cause1,
  input  logic [1:0]             out_pop
`ifdef IFQ_HWM_EN
  ,output logic [$clog2(DEPTH):0] fq_hwm
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = 65 + CAUSE_W;

  // Entry layout: {pc, inst, excp, cause}
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic            w_stall;
  logic [1:0]      w_npush;
  logic [1:0]      w_npop;
  logic [c_CW-1:0] w_count_next;
  logic [c_AW-1:0] w_tail1;
  logic [c_AW-1:0] w_head1;
  logic [c_EW-1:0] w_ent0;
  logic [c_EW-1:0] w_ent1;
  logic [c_EW-1:0] w_rd0;
  logic [c_EW-1:0] w_rd1;

  // Stall looks only at the registered count, never at the same-cycle pop.
  assign w_stall = (r_count > c_CW'(DEPTH - 2));

  assign w_npush = (flush || w_stall || !in_valid[0]) ? 2'd0 :
                   (in_valid[1] ? 2'd2 : 2'd1);
  assign w_npop  = (flush || !out_pop[0]) ? 2'd0 :
                   (out_pop[1] ? 2'd2 : 2'd1);

  assign w_count_next = flush ? '0 :
                        (r_count + c_CW'(w_npush) - c_CW'(w_npop));

  assign w_tail1 = r_tail + 1'b1;
  assign w_head1 = r_head + 1'b1;
  assign w_ent0  = {in_pc0, in_inst0, in_excp0, in_cause0};
  assign w_ent1  = {in_pc1, in_inst1, in_excp1, in_cause1};

  always_ff @(posedge clk) begin
    if (w_npush != 2'd0) begin
      r_mem[r_tail] <= w_ent0;
    end
    if (w_npush == 2'd2) begin
      r_mem[w_tail1] <= w_ent1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_AW'(w_npop);
      r_tail  <= r_tail + c_AW'(w_npush);
      r_count <= w_count_next;
    end
  end

  assign w_rd0 = r_mem[r_head];
  assign w_rd1 = r_mem[w_head1];

  assign fq_full_stall = w_stall;
  assign out_valid     = {(r_count > c_CW'(1)), (r_count != '0)};

  // Data is forced to zero behind a low valid so decode never sees stale storage.
  assign out_pc0    = out_valid[0] ? w_rd0[c_EW-1 -: 32]          : '0;
  assign out_inst0  = out_valid[0] ? w_rd0[CAUSE_W+32 -: 32]      : '0;
  assign out_excp0  = out_valid[0] ? w_rd0[CAUSE_W]               : 1'b0;
  assign out_cause0 = out_valid[0] ? w_rd0[CAUSE_W-1:0]           : '0;
  assign out_pc1    = out_valid[1] ? w_rd1[c_EW-1 -: 32]          : '0;
  assign out_inst1  = out_valid[1] ? w_rd1[CAUSE_W+32 -: 32]      : '0;
  assign out_excp1  = out_valid[1] ? w_rd1[CAUSE_W]               : 1'b0;
  assign out_cause1 = out_valid[1] ? w_rd1[CAUSE_W-1:0]           : '0;

`ifdef IFQ_HWM_EN
  logic [c_CW-1:0] r_hwm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (w_count_next > r_hwm) begin
      r_hwm <= w_count_next;
    end
  end

  assign fq_hwm = r_hwm;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (in_valid != 2'b10) else $error("inst_fetch_queue: illegal in_valid=10");
      assert (out_pop != 2'b10) else $error("inst_fetch_queue: illegal out_pop=10");
      assert ((out_pop & ~out_valid) == 2'b00) else $error("inst_fetch_queue: pop beyond out_valid");
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module   : tb_inst_fetch_queue
// Brief    : Randomized scoreboard bench for inst_fetch_queue against a queue model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

  localparam int DEPTH   = 8;
  localparam int CAUSE_W = 7;
  localparam int N_CYC   = 3000;

  logic clk;
  logic rst;
  logic flush;
  logic [1:0] in_valid;
  logic [31:0] in_pc0, in_pc1, in_inst0, in_inst1;
  logic in_excp0, in_excp1;
  logic [CAUSE_W-1:0] in_cause0, in_cause1;
  logic fq_full_stall;
  logic [1:0] out_valid;
  logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
  logic out_excp0, out_excp1;
  logic [CAUSE_W-1:0] out_cause0, out_cause1;
  logic [1:0] out_pop;
`ifdef IFQ_HWM_EN
  logic [3:0] fq_hwm;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH), .CAUSE_W(CAUSE_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc0(in_pc0), .in_pc1(in_pc1), .in_inst0(in_inst0), .in_inst1(in_inst1),
    .in_excp0(in_excp0), .in_excp1(in_excp1),
    .in_cause0(in_cause0), .in_cause1(in_cause1),
    .fq_full_stall(fq_full_stall), .out_valid(out_valid),
    .out_pc0(out_pc0), .out_pc1(out_pc1),
    .out_inst0(out_inst0), .out_inst1(out_inst1),
    .out_excp0(out_excp0), .out_excp1(out_excp1),
    .out_cause0(out_cause0), .out_cause1(out_cause1),
    .out_pop(out_pop)
`ifdef IFQ_HWM_EN
    ,.fq_hwm(fq_hwm)
`endif
  );

  typedef struct {
    logic [31:0]        pc;
    logic [31:0]        inst;
    logic               excp;
    logic [CAUSE_W-1:0] cause;
  } ent_t;

  typedef struct {
    logic [1:0]         ov;
    logic               stall;
    logic [31:0]        pc0, pc1, i0, i1;
    logic               e0, e1;
    logic [CAUSE_W-1:0] c0, c1;
    logic [3:0]         hwm;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   mhwm;
  int   compared;
  int   mismatched;
  bit   done;
  logic [31:0] pc_gen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s actual=0x%08h required=0x%08h @%0t", name, act, req, $time);
    end
  endtask

  // Applies the inputs that were just clocked in to the reference queue.
  task automatic model_apply();
    bit st;
    int npop;
    ent_t e;
    if (rst) begin
      mq.delete();
      mhwm = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      st   = (DEPTH - mq.size()) < 2;
      npop = (out_pop == 2'b11) ? 2 : (out_pop == 2'b01) ? 1 : 0;
      for (int k = 0; k < npop; k++) void'(mq.pop_front());
      if (!st && in_valid[0]) begin
        e.pc = in_pc0; e.inst = in_inst0; e.excp = in_excp0; e.cause = in_cause0;
        mq.push_back(e);
        if (in_valid[1]) begin
          e.pc = in_pc1; e.inst = in_inst1; e.excp = in_excp1; e.cause = in_cause1;
          mq.push_back(e);
        end
      end
    end
    if (!rst && mq.size() > mhwm) mhwm = mq.size();
  endtask

  function automatic exp_t snapshot();
    exp_t x;
    x.ov    = (mq.size() >= 2) ? 2'b11 : (mq.size() == 1) ? 2'b01 : 2'b00;
    x.stall = (DEPTH - mq.size()) < 2;
    x.pc0 = '0; x.i0 = '0; x.e0 = 1'b0; x.c0 = '0;
    x.pc1 = '0; x.i1 = '0; x.e1 = 1'b0; x.c1 = '0;
    if (mq.size() >= 1) begin
      x.pc0 = mq[0].pc; x.i0 = mq[0].inst; x.e0 = mq[0].excp; x.c0 = mq[0].cause;
    end
    if (mq.size() >= 2) begin
      x.pc1 = mq[1].pc; x.i1 = mq[1].inst; x.e1 = mq[1].excp; x.c1 = mq[1].cause;
    end
    x.hwm = 4'(mhwm);
    return x;
  endfunction

  // Driver: update model for the edge just taken, queue expectation, drive next inputs.
  initial begin
    int cnt;
    int phase;
    int r;
    bit st;
    compared = 0; mismatched = 0; done = 1'b0; mhwm = 0;
    pc_gen = 32'h1c00_0000;
    rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
    in_pc0 = '0; in_pc1 = '0; in_inst0 = '0; in_inst1 = '0;
    in_excp0 = 1'b0; in_excp1 = 1'b0; in_cause0 = '0; in_cause1 = '0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      #2;
      model_apply();
      exp_q.push_back(snapshot());

      cnt   = mq.size();
      st    = (DEPTH - cnt) < 2;
      rst   = (cyc < 2) || ($urandom_range(0, 199) == 0);
      flush = (cyc > 12) && ($urandom_range(0, 24) == 0);
      phase = (cyc / 64) % 3;

      if (cyc >= 2 && cyc < 6) begin
        in_valid = 2'b11; out_pop = 2'b00;
      end else if (cyc >= 6 && cyc < 9) begin
        in_valid = 2'b11; out_pop = (cnt >= 2) ? 2'b11 : 2'b00;
      end else begin
        r = $urandom_range(0, 9);
        in_valid = (r < (phase == 0 ? 7 : phase == 1 ? 4 : 2)) ? 2'b11 :
                   (r < 8) ? 2'b01 : 2'b00;
        r = $urandom_range(0, 9);
        if (r < (phase == 0 ? 7 : phase == 1 ? 4 : 1)) out_pop = 2'b00;
        else if (r < 6 || cnt < 2) out_pop = 2'b01;
        else out_pop = 2'b11;
        if (cnt == 0) out_pop = 2'b00;
        if (cnt == 1 && out_pop == 2'b11) out_pop = 2'b01;
      end

      in_pc0    = pc_gen;
      in_pc1    = pc_gen + 32'd4;
      in_inst0  = $urandom;
      in_inst1  = $urandom;
      in_excp0  = ($urandom_range(0, 7) == 0);
      in_excp1  = ($urandom_range(0, 7) == 0);
      in_cause0 = CAUSE_W'($urandom);
      in_cause1 = CAUSE_W'($urandom);

      if (rst || flush) pc_gen = {$urandom} & 32'hffff_fffc;
      else if (!st && in_valid == 2'b11) pc_gen = pc_gen + 32'd8;
      else if (!st && in_valid == 2'b01) pc_gen = pc_gen + 32'd4;
    end

    @(posedge clk);
    @(posedge clk);
    done = 1'b1;
  end

  // Monitor: compare DUT outputs mid-cycle against the oldest queued expectation.
  initial begin
    exp_t x;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("out_valid",  32'(out_valid),     32'(x.ov));
        chk("stall",      32'(fq_full_stall), 32'(x.stall));
        chk("out_pc0",    out_pc0,            x.pc0);
        chk("out_pc1",    out_pc1,            x.pc1);
        chk("out_inst0",  out_inst0,          x.i0);
        chk("out_inst1",  out_inst1,          x.i1);
        chk("out_excp0",  32'(out_excp0),     32'(x.e0));
        chk("out_excp1",  32'(out_excp1),     32'(x.e1));
        chk("out_cause0", 32'(out_cause0),    32'(x.c0));
        chk("out_cause1", 32'(out_cause1),    32'(x.c1));
`ifdef IFQ_HWM_EN
        chk("fq_hwm",     32'(fq_hwm),        32'(x.hwm));
`endif
      end
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #((N_CYC + 100) * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
